pipeline_dec_skid: RTL and testbench

PIPELINE_DEC_SKID -- requirements
Module: pipeline_dec_skid

---
 rtl/pipeline_dec_skid.sv | 109 ++++++++++
 tb/tb_pipeline_dec_skid.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_dec_skid.sv
// Two-entry skid buffer between decode and execute. All state moves on the falling clock edge.
// Handshake outputs come from registered state only. An empty stage drives a NOP bubble.
module pipeline_dec_skid #(
  parameter int unsigned XLEN       = 32,
  parameter logic [6:0]  NOP_OPCODE = 7'h13,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  // 32 bits of instruction fields, then imm, rs1_data, rs2_data, pc (XLEN each)
  input  logic [32+4*XLEN-1:0]   dec_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [32+4*XLEN-1:0]   dec_out,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int unsigned PW = 32 + 4 * XLEN;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [PW-1:0] BUBBLE = {{(PW - 7){1'b0}}, NOP_OPCODE};

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    m_q, s_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic in_fire, out_fire;
  logic m_load_in, m_load_s, s_load;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    m_load_in = 1'b0;
    m_load_s  = 1'b0;
    s_load    = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d   = ST_ONE;
            m_load_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && !out_fire) begin
            state_d = ST_FULL;
            s_load  = 1'b1;
          end else if (in_fire && out_fire) begin
            m_load_in = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d  = ST_ONE;
            m_load_s = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload storage needs no reset: contents are invisible while the entry is invalid.
  always_ff @(negedge clk) begin
    if (m_load_in) begin
      m_q <= dec_in;
    end else if (m_load_s) begin
      m_q <= s_q;
    end
    if (s_load) begin
      s_q <= dec_in;
    end
  end

  // Saturating back-pressure counter; deliberately survives flush.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign dec_out   = out_valid ? m_q : BUBBLE;

endmodule

// File: tb/tb_pipeline_dec_skid.sv
// Bench for pipeline_dec_skid: a scoreboard on the default instance, plus a second instance
// (XLEN=64, CNT_W=4) that covers wide payloads and counter saturation.
module tb_pipeline_dec_skid;

  localparam int PW  = 160;
  localparam int PW2 = 288;
  localparam logic [PW-1:0]  BUB   = 160'h13;
  localparam logic [PW2-1:0] BUB2  = 288'h13;
  localparam logic [PW2-1:0] X64   = {64'h0000_0000_0000_0400, 64'h2222_3333_4444_5555,
                                      64'h6666_7777_8888_9999, 64'hFFFF_0000_1234_5678,
                                      7'h00, 5'd4, 5'd3, 3'd2, 5'd5, 7'h13};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [PW-1:0] dec_in, dec_out;
  logic [15:0]   stall_cnt;

  logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [PW2-1:0] b_dec_in, b_dec_out;
  logic [3:0]     b_stall_cnt;

  int checks = 0;
  int failures = 0;
  logic [PW-1:0] sb[$];

  pipeline_dec_skid dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .dec_in(dec_in), .out_valid(out_valid), .out_ready(out_ready), .dec_out(dec_out),
    .stall_cnt(stall_cnt)
  );

  pipeline_dec_skid #(.XLEN(64), .NOP_OPCODE(7'h13), .CNT_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .dec_in(b_dec_in), .out_valid(b_out_valid), .out_ready(b_out_ready), .dec_out(b_dec_out),
    .stall_cnt(b_stall_cnt)
  );

  task automatic chk(input string nm, input logic [PW2-1:0] act, input logic [PW2-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Inputs change just after the active (falling) edge; everything is sampled mid-cycle.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] mk(input logic [4:0] rd, input logic [31:0] imm,
                                       input logic [31:0] pc);
    return {pc, imm ^ 32'h5555_5555, imm + 32'h11, imm, 7'h20, 5'd2, 5'd1, 3'd0, rd, 7'h33};
  endfunction

  // Scoreboard monitor: accepted beats are queued, delivered beats are popped and compared.
  always @(posedge clk) begin
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got %0h expected no beat", dec_out);
        end else begin
          chk("sb_beat", PW2'(dec_out), PW2'(sb.pop_front()));
        end
      end
      if (in_valid && in_ready) sb.push_back(dec_in);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; dec_in = '0; out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_dec_in = '0; b_out_ready = 1'b0;
    #3;
    chk_b("rst_in_ready", in_ready, 1'b1);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk("rst_bubble", PW2'(dec_out), PW2'(BUB));
    chk("rst_stall_cnt", PW2'(stall_cnt), PW2'(16'd0));
    step(); step();
    rst_n = 1'b1;

    // Streaming, 8 beats back-to-back
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      dec_in   = mk(5'(k + 1), 32'(k * 3), 32'h100 + 32'(4 * k));
      chk_b("stream_in_ready", in_ready, 1'b1);
      step();
      chk_b("stream_out_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    step();
    chk_b("stream_drained", out_valid, 1'b0);
    chk("stream_stall_cnt", PW2'(stall_cnt), PW2'(16'd0));
    chk("stream_sb_empty", PW2'(sb.size()), PW2'(0));

    // Back-pressure: two accepted, third held upstream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    dec_in    = mk(5'd10, 32'h10, 32'h200);
    step();
    dec_in = mk(5'd11, 32'h11, 32'h204);
    step();
    chk_b("bp_in_ready_full", in_ready, 1'b0);
    dec_in = mk(5'd12, 32'h12, 32'h208);
    step();
    chk_b("bp_in_ready_held", in_ready, 1'b0);
    step();
    chk("bp_stall_cnt", PW2'(stall_cnt), PW2'(16'd3));
    out_ready = 1'b1;
    step();
    chk_b("bp_in_ready_free", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    chk_b("bp_drained", out_valid, 1'b0);
    chk("bp_stall_hold", PW2'(stall_cnt), PW2'(16'd3));
    chk("bp_sb_empty", PW2'(sb.size()), PW2'(0));

    // Flush while FULL with a beat offered, then flush in ONE against a real in_fire
    out_ready = 1'b0;
    in_valid  = 1'b1;
    dec_in    = mk(5'd13, 32'h13, 32'h300);
    step();
    dec_in = mk(5'd14, 32'h14, 32'h304);
    step();
    dec_in = mk(5'd15, 32'h15, 32'h308);
    flush  = 1'b1;
    step();
    chk_b("flush_full_out_valid", out_valid, 1'b0);
    chk("flush_full_bubble", PW2'(dec_out), PW2'(BUB));
    chk_b("flush_full_in_ready", in_ready, 1'b1);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    chk_b("flush_full_no_beat", out_valid, 1'b0);
    in_valid = 1'b1;
    dec_in   = mk(5'd16, 32'h16, 32'h30C);
    step();
    dec_in = mk(5'd17, 32'h17, 32'h310);
    flush  = 1'b1;
    step();
    chk_b("flush_one_out_valid", out_valid, 1'b0);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    chk_b("flush_one_no_beat", out_valid, 1'b0);
    chk("flush_stall_cnt", PW2'(stall_cnt), PW2'(16'd6));
    chk("flush_sb_empty", PW2'(sb.size()), PW2'(0));

    // Asynchronous reset between edges while FULL
    in_valid = 1'b1;
    dec_in   = mk(5'd18, 32'h18, 32'h400);
    step();
    dec_in = mk(5'd19, 32'h19, 32'h404);
    step();
    in_valid = 1'b0;
    chk_b("pre_reset_full", in_ready, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_b("rst_async_in_ready", in_ready, 1'b1);
    chk_b("rst_async_out_valid", out_valid, 1'b0);
    chk("rst_async_bubble", PW2'(dec_out), PW2'(BUB));
    chk("rst_async_stall_cnt", PW2'(stall_cnt), PW2'(16'd0));
    step(); step();
    rst_n = 1'b1;

    // First falling edge after reset accepts, visible right after that edge
    out_ready = 1'b1;
    in_valid  = 1'b1;
    dec_in    = mk(5'd20, 32'h20, 32'h500);
    step();
    in_valid = 1'b0;
    chk_b("post_reset_accept", out_valid, 1'b1);
    chk("post_reset_latency", PW2'(dec_out), PW2'(mk(5'd20, 32'h20, 32'h500)));
    step();
    chk_b("post_reset_drained", out_valid, 1'b0);
    chk("post_reset_sb_empty", PW2'(sb.size()), PW2'(0));

    // XLEN=64 pass-through and CNT_W=4 saturation
    chk("x64_rst_bubble", b_dec_out, BUB2);
    b_in_valid = 1'b1;
    b_dec_in   = X64;
    step();
    b_in_valid = 1'b0;
    chk_b("x64_out_valid", b_out_valid, 1'b1);
    chk("x64_payload", b_dec_out, X64);
    chk("x64_imm", PW2'(b_dec_out[95:32]), PW2'(64'hFFFF_0000_1234_5678));
    repeat (10) step();
    chk("sat_mid", PW2'(b_stall_cnt), PW2'(4'd10));
    repeat (10) step();
    chk("sat_full", PW2'(b_stall_cnt), PW2'(4'hF));
    b_out_ready = 1'b1;
    step();
    chk_b("x64_drained", b_out_valid, 1'b0);
    chk("sat_hold", PW2'(b_stall_cnt), PW2'(4'hF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
